// File: rtl/pid_wb_pkg.sv
// Shared definitions for the PID-core Wishbone register slave
// and the arbiter that fronts it.
package pid_wb_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 32;

    localparam logic [15:0] REG_KP = 16'h0000;
    localparam logic [15:0] REG_KI = 16'h0004;
    localparam logic [15:0] REG_KD = 16'h0008;
    localparam logic [15:0] REG_SP = 16'h000C;
    localparam logic [15:0] REG_PV = 16'h0010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/wb_pid_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after
// the previous owner, wrapping modulo NUM_M.
module rr_pick
    import pid_wb_pkg::*;
#(
    parameter int NUM_M = 2,
    parameter int IW    = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [IW-1:0]    idx,
    output logic             valid
);

    logic [IW-1:0] cand;

    // Scan last+1, last+2, ... and keep the first requester found.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_M; k++) begin
            cand = IW'((int'(last) + k) % NUM_M);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/wb_pid_arbiter.sv
// Round-robin Wishbone arbiter in front of the PID register slave:
// zero-latency grant from idle, bus lock per CYC, stalled-slave watchdog.
module wb_pid_arbiter
    import pid_wb_pkg::*;
#(
    parameter int NUM_M   = 2,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [NUM_M-1:0]    m_cyc_i,
    input  logic [NUM_M-1:0]    m_stb_i,
    input  logic [NUM_M-1:0]    m_we_i,
    input  logic [NUM_M*AW-1:0] m_adr_i,
    input  logic [NUM_M*DW-1:0] m_dat_i,
    output logic [NUM_M-1:0]    m_ack_o,
    output logic [NUM_M-1:0]    m_err_o,
    output logic [DW-1:0]       m_dat_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [AW-1:0]       s_adr_o,
    output logic [DW-1:0]       s_dat_o,
    input  logic                s_ack_i,
    input  logic [DW-1:0]       s_dat_i,
    output logic [NUM_M-1:0]    gnt_o
);

    localparam int IW = $clog2(NUM_M);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [IW-1:0] gnt_q;
    logic [IW-1:0] last_q;
    logic [IW-1:0] win;
    logic [IW-1:0] sel;
    logic          win_ok;
    logic          busy;
    logic          expire;
    logic [TW-1:0] tmr;

    rr_pick #(
        .NUM_M(NUM_M),
        .IW   (IW)
    ) u_pick (
        .req  (m_cyc_i),
        .last (last_q),
        .idx  (win),
        .valid(win_ok)
    );

    // Bus select: fresh winner when idle, locked owner otherwise.
    always_comb begin
        sel  = gnt_q;
        busy = 1'b0;
        case (state)
            ST_IDLE: begin
                sel  = win;
                busy = win_ok;
            end
            ST_OWNED: busy = m_cyc_i[gnt_q];
            default:  busy = 1'b0;
        endcase
        if (wb_rst_i) busy = 1'b0;
        expire = busy && m_stb_i[sel] && !s_ack_i && (tmr == TLAST);
    end

    // State, owner, rotation pointer and watchdog registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state  <= ST_IDLE;
            gnt_q  <= '0;
            last_q <= IW'(NUM_M - 1);
            tmr    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && win_ok) gnt_q <= win;
            if ((state == ST_OWNED && !m_cyc_i[gnt_q]) || state == ST_ABORT)
                last_q <= gnt_q;
            if (state == ST_ABORT || !s_stb_o || s_ack_i) tmr <= '0;
            else if (tmr != TMAX) tmr <= tmr + 1'b1;
        end
    end

    // Next state; an ACK on the expiry cycle suppresses the abort.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (win_ok) state_nxt = expire ? ST_ABORT : ST_OWNED;
            end
            ST_OWNED: begin
                if (!m_cyc_i[gnt_q]) state_nxt = ST_IDLE;
                else if (expire)     state_nxt = ST_ABORT;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Slave-side mux and owner-only ACK/ERR steering.
    always_comb begin
        s_cyc_o = busy;
        s_stb_o = busy & m_stb_i[sel];
        s_we_o  = busy & m_we_i[sel];
        s_adr_o = busy ? m_adr_i[int'(sel)*AW +: AW] : '0;
        s_dat_o = busy ? m_dat_i[int'(sel)*DW +: DW] : '0;
        m_ack_o = '0;
        m_err_o = '0;
        gnt_o   = '0;
        if (busy) begin
            gnt_o[sel]   = 1'b1;
            m_ack_o[sel] = s_ack_i & m_stb_i[sel];
        end
        if (state == ST_ABORT && !wb_rst_i) m_err_o[gnt_q] = 1'b1;
        m_dat_o = wb_rst_i ? '0 : s_dat_i;
    end

endmodule

// File: tb/tb_wb_pid_arbiter.sv
// Scoreboard bench for wb_pid_arbiter: random masters, a
// behavioural slave, and a negedge monitor checking responses.
module tb_wb_pid_arbiter;

    localparam int NUM_M   = 2;
    localparam int AW      = 16;
    localparam int DW      = 32;
    localparam int TIMEOUT = 4;

    typedef struct packed {
        logic          err;
        logic          chk;
        logic [DW-1:0] data;
        int            lat;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NUM_M-1:0]    pk_cyc, pk_stb, pk_we;
    logic [NUM_M*AW-1:0] pk_adr;
    logic [NUM_M*DW-1:0] pk_dat;
    logic [NUM_M-1:0]    m_ack, m_err, gnt;
    logic [DW-1:0]       m_rdat;
    logic                s_cyc, s_stb, s_we, s_ack;
    logic [AW-1:0]       s_adr;
    logic [DW-1:0]       s_wdat, s_rdat;

    logic          cyc [NUM_M];
    logic          stb [NUM_M];
    logic          we  [NUM_M];
    logic [AW-1:0] adr [NUM_M];
    logic [DW-1:0] dat [NUM_M];

    logic [NUM_M-1:0] ack_s = '0;
    logic [NUM_M-1:0] err_s = '0;
    exp_t exp_q [NUM_M][$];
    int   checks = 0;
    int   errors = 0;
    int   wcnt   = 0;

    always #5 clk = ~clk;

    wb_pid_arbiter #(
        .NUM_M(NUM_M), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .m_cyc_i (pk_cyc),
        .m_stb_i (pk_stb),
        .m_we_i  (pk_we),
        .m_adr_i (pk_adr),
        .m_dat_i (pk_dat),
        .m_ack_o (m_ack),
        .m_err_o (m_err),
        .m_dat_o (m_rdat),
        .s_cyc_o (s_cyc),
        .s_stb_o (s_stb),
        .s_we_o  (s_we),
        .s_adr_o (s_adr),
        .s_dat_o (s_wdat),
        .s_ack_i (s_ack),
        .s_dat_i (s_rdat),
        .gnt_o   (gnt)
    );

    always_comb begin
        pk_cyc = '0;
        pk_stb = '0;
        pk_we  = '0;
        pk_adr = '0;
        pk_dat = '0;
        for (int i = 0; i < NUM_M; i++) begin
            pk_cyc[i] = cyc[i];
            pk_stb[i] = stb[i];
            pk_we[i]  = we[i];
            pk_adr[i*AW +: AW] = adr[i];
            pk_dat[i*DW +: DW] = dat[i];
        end
    end

    function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
        return {a, ~a};
    endfunction

    // Slave: waits adr[1:0] cycles then ACKs; never ACKs if adr[7] is set.
    always @(posedge clk) begin
        if (s_stb && !s_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end
    assign s_ack  = s_stb && !s_adr[7] && (wcnt == int'(s_adr[1:0]));
    assign s_rdat = s_stb ? rd_val(s_adr) : '0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [NUM_M-1:0] oh);
        int r = 0;
        for (int i = 0; i < NUM_M; i++) if (oh[i]) r = i;
        return r;
    endfunction

    // Monitor: bus routing, fairness, idle gaps and response scoreboard.
    initial begin
        int   last = NUM_M - 1;
        int   run  = 0;
        int   o, w;
        logic [NUM_M-1:0] prev = '0;
        logic [NUM_M-1:0] ew;
        exp_t e;
        logic [127:0] act, ex;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_outputs",
                    {s_cyc, s_stb, s_we, s_adr, s_wdat, m_ack, m_err, m_rdat, gnt},
                    '0);
                last  = NUM_M - 1;
                run   = 0;
                prev  = '0;
                ack_s = '0;
                err_s = '0;
                continue;
            end
            if (s_stb) run++;
            chk("gnt_onehot", {31'd0, $onehot0(gnt)}, 128'd1);
            if (gnt != 0) begin
                o = idx_of(gnt);
                chk("bus_route", {s_cyc, s_stb, s_we, s_adr, s_wdat},
                    {1'b1, stb[o], we[o], adr[o], dat[o]});
            end else begin
                chk("bus_idle", {s_cyc, s_stb}, 2'b00);
            end
            if (prev == 0 && gnt != 0) begin
                w = -1;
                for (int k = 1; k <= NUM_M; k++)
                    if (w < 0 && cyc[(last + k) % NUM_M]) w = (last + k) % NUM_M;
                ew = '0;
                if (w >= 0) ew[w] = 1'b1;
                chk("rr_winner", gnt, ew);
            end
            if (prev != 0 && gnt != 0) chk("bus_lock_gap", gnt, prev);
            if (prev != 0 && gnt == 0) last = idx_of(prev);
            chk("resp_exclusive",
                {(m_ack & ~gnt) != 0, (m_ack & m_err) != 0, !$onehot0(m_err)}, 3'b000);
            for (int m = 0; m < NUM_M; m++) begin
                if (m_ack[m] || m_err[m]) begin
                    checks++;
                    if (exp_q[m].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_resp m%0d: ack %b err %b, none outstanding",
                                 m, m_ack[m], m_err[m]);
                    end else begin
                        checks--;
                        e   = exp_q[m].pop_front();
                        act = {m_err[m], m_ack[m], 32'(run), e.chk ? m_rdat : e.data};
                        ex  = {e.err, !e.err, 32'(e.lat), e.data};
                        chk($sformatf("resp_m%0d", m), act, ex);
                    end
                    run = 0;
                end
            end
            ack_s = m_ack;
            err_s = m_err;
            prev  = gnt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input int m, output bit got_err);
        int n = 0;
        bit done = 0;
        got_err = 0;
        while (!done && n < 100) begin
            tick();
            n++;
            if (ack_s[m] || err_s[m]) begin
                done    = 1;
                got_err = err_s[m];
            end
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL resp_timeout m%0d: no ack/err in %0d cycles, required one", m, n);
            got_err = 1;
        end
    endtask

    // One master transaction of nb beats; ERR ends it early.
    task automatic do_xfer(input int m, input int nb, input bit rnd,
                           input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                           input logic w0);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          w;
        exp_t          e;
        bit            ge;
        for (int b = 0; b < nb; b++) begin
            a = a0;
            d = d0;
            w = w0;
            if (rnd) begin
                a    = AW'($urandom);
                a[7] = ($urandom_range(0, 7) == 0);
                d    = $urandom;
                w    = 1'($urandom_range(0, 1));
            end
            e.err  = a[7];
            e.lat  = a[7] ? TIMEOUT : int'(a[1:0]) + 1;
            e.chk  = !w && !a[7];
            e.data = rd_val(a);
            exp_q[m].push_back(e);
            cyc[m] = 1'b1;
            stb[m] = 1'b1;
            adr[m] = a;
            dat[m] = d;
            we[m]  = w;
            wait_resp(m, ge);
            if (ge) break;
        end
        cyc[m] = 1'b0;
        stb[m] = 1'b0;
        tick();
    endtask

    initial begin
        bit ge;
        for (int i = 0; i < NUM_M; i++) begin
            cyc[i] = 0; stb[i] = 0; we[i] = 0; adr[i] = '0; dat[i] = '0;
        end
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single-cycle write to SP reaches the slave in the grant cycle.
        fork
            do_xfer(0, 1, 0, 16'h000C, 32'h64, 1'b1);
            begin
                @(negedge clk);
                chk("t1_same_cycle", {s_cyc, s_stb, s_we, s_adr, s_wdat, gnt, m_ack},
                    {1'b1, 1'b1, 1'b1, 16'h000C, 32'h64, 2'b01, 2'b01});
            end
        join

        // Both masters hammering 1-beat transfers must alternate.
        fork
            repeat (4) do_xfer(0, 1, 0, 16'h0010, 32'h0, 1'b0);
            repeat (4) do_xfer(1, 1, 0, 16'h0004, 32'h0, 1'b0);
        join

        // m1 holds a 5-beat burst; m0 waits behind the lock.
        fork
            do_xfer(1, 5, 0, 16'h0001, 32'hA5A5_0001, 1'b1);
            begin
                repeat (2) tick();
                do_xfer(0, 1, 0, 16'h0008, 32'h0, 1'b0);
            end
        join

        // Silent slave -> abort; ACK on the expiry cycle -> normal ACK.
        do_xfer(0, 1, 0, 16'h0080, 32'h0, 1'b0);
        do_xfer(0, 1, 0, 16'h0003, 32'h0, 1'b0);

        // Reset while m1 owns the bus; m0 must win afterwards.
        cyc[1] = 1; stb[1] = 1; adr[1] = 16'h0083; we[1] = 0;
        repeat (2) tick();
        rst = 1'b1;
        cyc[0] = 1; stb[0] = 1; adr[0] = 16'h0010; we[0] = 0;
        @(negedge clk);
        chk("t6_rst_outputs", {s_cyc, s_stb, gnt, m_ack, m_err}, '0);
        tick();
        rst = 1'b0;
        exp_q[0].push_back('{err: 1'b0, chk: 1'b1, data: rd_val(16'h0010), lat: 1});
        exp_q[1].push_back('{err: 1'b1, chk: 1'b0, data: rd_val(16'h0083), lat: TIMEOUT});
        @(negedge clk);
        chk("t6_m0_wins", {gnt, m_ack}, {2'b01, 2'b01});
        tick();
        cyc[0] = 0; stb[0] = 0;
        wait_resp(1, ge);
        chk("t6_m1_err", {31'd0, ge}, 128'd1);
        cyc[1] = 0; stb[1] = 0;
        tick();

        // Random traffic from both masters.
        fork
            for (int t = 0; t < 40; t++) begin
                repeat ($urandom_range(0, 3)) tick();
                do_xfer(0, $urandom_range(1, 3), 1, '0, '0, 1'b0);
            end
            for (int t = 0; t < 40; t++) begin
                repeat ($urandom_range(0, 3)) tick();
                do_xfer(1, $urandom_range(1, 3), 1, '0, '0, 1'b0);
            end
        join

        repeat (10) tick();
        for (int m = 0; m < NUM_M; m++)
            chk($sformatf("drain_m%0d", m), 128'(exp_q[m].size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
